// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the mem_ctrl word-wide memory controller.
// Optional wait states are built only when MEM_CTRL_WAIT_EN is defined.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          DEF_DEPTH_LOG2  = 12;
    localparam logic [15:0] DEF_BASE_ADDR   = 16'h0000;
    localparam int          DEF_WAIT_CYCLES = 0;

    // Word index is in range when no bit at or above depth_log2 is set.
    function automatic logic word_mapped(
        input logic [14:0] idx,
        input int          depth_log2
    );
        return (32'(idx) >> depth_log2) == 32'd0;
    endfunction

endpackage

// File: rtl/mem_ctrl_ram.sv
// Single-port 16-bit RAM with per-byte write enables.
// Writes are synchronous; the read port is asynchronous and registered by the caller.
module mem_ctrl_ram
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [1:0]            wstrb,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wstrb[0]) mem[addr][7:0]  <= wdata[7:0];
            if (wstrb[1]) mem[addr][15:8] <= wdata[15:8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: request FSM, address decode and wait counter.
// Define MEM_CTRL_WAIT_EN to build the WAIT state and honour WAIT_CYCLES.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter logic [15:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [1:0]  mem_wstrb,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready
);

    state_t      state, state_nx;
    logic [15:0] cur_addr, cur_wdata;
    logic [1:0]  cur_wstrb;
    logic [15:0] offset;
    logic        mapped, commit, ram_we;
    logic [15:0] ram_rdata;
    logic        unused_bit;

`ifdef MEM_CTRL_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [3:0]  cnt, cnt_nx;
    logic [15:0] addr_q, wdata_q;
    logic [1:0]  wstrb_q;

    always_ff @(posedge clk) begin
        if (rst) cnt <= 4'd0;
        else     cnt <= cnt_nx;
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && mem_valid) begin
            addr_q  <= mem_addr;
            wstrb_q <= mem_wstrb;
            wdata_q <= mem_wdata;
        end
    end

    // In IDLE the live request is used so a zero-wait access commits at once.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cur_addr  = addr_q;
        cur_wstrb = wstrb_q;
        cur_wdata = wdata_q;
        unique case (state)
            IDLE: begin
                cur_addr  = mem_addr;
                cur_wstrb = mem_wstrb;
                cur_wdata = mem_wdata;
                if (mem_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                    end else begin
                        cnt_nx   = WAIT_LOAD;
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nx = RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^4'(WAIT_CYCLES);

    always_comb begin
        state_nx  = state;
        cur_addr  = mem_addr;
        cur_wstrb = mem_wstrb;
        cur_wdata = mem_wdata;
        unique case (state)
            IDLE:    if (mem_valid) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
`endif

    assign offset     = cur_addr - BASE_ADDR;
    assign mapped     = word_mapped(offset[15:1], DEPTH_LOG2);
    assign unused_bit = offset[0];
    // Gating with rst keeps a reset on the entry edge from committing.
    assign commit     = (state_nx == RESP) && !rst;
    assign ram_we     = commit && mapped && (cur_wstrb != 2'b00);

    mem_ctrl_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .wstrb(cur_wstrb),
        .addr (offset[DEPTH_LOG2:1]),
        .wdata(cur_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_rdata <= 16'h0000;
        end else begin
            state <= state_nx;
            if (commit && cur_wstrb == 2'b00)
                mem_rdata <= mapped ? ram_rdata : 16'h0000;
        end
    end

    assign mem_ready = (state == RESP);

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised self-checking bench for mem_ctrl against a word-array model.
// Wait-state scenarios are exercised when MEM_CTRL_WAIT_EN is defined.
module tb_mem_ctrl;

`ifdef MEM_CTRL_WAIT_EN
    localparam int W = 3;
`else
    localparam int W = 0;
`endif
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [1:0]  mem_wstrb = 2'b00;
    logic [15:0] mem_addr = 16'h0;
    logic [15:0] mem_wdata = 16'h0;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int passed = 0;

    logic [15:0] model [int];
    logic [15:0] exp_rd;

    mem_ctrl #(
        .DEPTH_LOG2 (12),
        .BASE_ADDR  (16'h0000),
        .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_wstrb(mem_wstrb),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic bit is_mapped(input logic [15:0] a);
        return ((int'(a) & 32'hFFFF) / 2) < DEPTH;
    endfunction

    function automatic int widx(input logic [15:0] a);
        return (int'(a) & 32'hFFFF) / 2;
    endfunction

    // Apply one access to the model; returns the expected mem_rdata afterwards.
    task automatic model_access(input logic [15:0] a, input logic [1:0] s,
                                input logic [15:0] d);
        logic [15:0] old;
        if (!is_mapped(a)) begin
            if (s == 2'b00) exp_rd = 16'h0000;
            return;
        end
        old = model.exists(widx(a)) ? model[widx(a)] : 16'h0000;
        if (s == 2'b00) begin
            exp_rd = old;
        end else begin
            if (s[0]) old[7:0]  = d[7:0];
            if (s[1]) old[15:8] = d[15:8];
            model[widx(a)] = old;
        end
    endtask

    // Drive one request, hold it until mem_ready, then look one cycle later.
    task automatic txn(input logic [15:0] a, input logic [1:0] s, input logic [15:0] d,
                       output logic [15:0] rd, output int lat, output logic after);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wstrb = s;
        mem_wdata = d;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = i;
                break;
            end
        end
        mem_valid = 1'b0;
        rd = mem_rdata;
        @(posedge clk); #1;
        after = mem_ready;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", mem_ready);
        else passed++;
        checks++;
        if (mem_rdata !== 16'h0000) $display("FAIL reset_rdata got=%h exp=0000", mem_rdata);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 16'h0000;
    endtask

    task automatic test_basic;
        logic [15:0] rd;
        int lat;
        logic after;
        txn(16'h0010, 2'b11, 16'hBEEF, rd, lat, after);
        model_access(16'h0010, 2'b11, 16'hBEEF);
        checks++;
        if (lat != W + 1) $display("FAIL basic_wr_latency got=%0d exp=%0d", lat, W + 1);
        else passed++;
        checks++;
        if (after !== 1'b0) $display("FAIL basic_wr_pulse got=%b exp=0", after);
        else passed++;
        checks++;
        if (rd !== 16'h0000) $display("FAIL basic_wr_rdata got=%h exp=0000", rd);
        else passed++;
        txn(16'h0010, 2'b00, 16'h0000, rd, lat, after);
        model_access(16'h0010, 2'b00, 16'h0000);
        checks++;
        if (lat != W + 1) $display("FAIL basic_rd_latency got=%0d exp=%0d", lat, W + 1);
        else passed++;
        checks++;
        if (after !== 1'b0) $display("FAIL basic_rd_pulse got=%b exp=0", after);
        else passed++;
        checks++;
        if (rd !== 16'hBEEF) $display("FAIL basic_rd_data got=%h exp=BEEF", rd);
        else passed++;
    endtask

    task automatic test_byte_strobe;
        logic [15:0] rd;
        int lat;
        logic after;
        txn(16'h0010, 2'b01, 16'h1234, rd, lat, after);
        model_access(16'h0010, 2'b01, 16'h1234);
        txn(16'h0011, 2'b00, 16'h0000, rd, lat, after);
        checks++;
        if (rd !== 16'hBE34) $display("FAIL strobe_lo got=%h exp=BE34", rd);
        else passed++;
        txn(16'h0010, 2'b10, 16'h56AA, rd, lat, after);
        model_access(16'h0010, 2'b10, 16'h56AA);
        txn(16'h0010, 2'b00, 16'h0000, rd, lat, after);
        checks++;
        if (rd !== 16'h5634) $display("FAIL strobe_hi got=%h exp=5634", rd);
        else passed++;
        exp_rd = rd;
    endtask

    task automatic test_unmapped;
        logic [15:0] rd;
        int lat;
        logic after;
        txn(16'h1000, 2'b11, 16'h0F0F, rd, lat, after);
        model_access(16'h1000, 2'b11, 16'h0F0F);
        txn(16'hF000, 2'b11, 16'hDEAD, rd, lat, after);
        checks++;
        if (lat != W + 1) $display("FAIL unmapped_wr_latency got=%0d exp=%0d", lat, W + 1);
        else passed++;
        txn(16'hF000, 2'b00, 16'h0000, rd, lat, after);
        checks++;
        if (lat != W + 1 || after !== 1'b0)
            $display("FAIL unmapped_rd_handshake got=%0d/%b exp=%0d/0", lat, after, W + 1);
        else passed++;
        checks++;
        if (rd !== 16'h0000) $display("FAIL unmapped_rd_data got=%h exp=0000", rd);
        else passed++;
        txn(16'h1000, 2'b00, 16'h0000, rd, lat, after);
        checks++;
        if (rd !== 16'h0F0F) $display("FAIL unmapped_no_alias got=%h exp=0F0F", rd);
        else passed++;
        exp_rd = rd;
    endtask

    task automatic test_random;
        logic [15:0] rd, a, d;
        logic [1:0] s;
        int lat;
        logic after;
        for (int i = 0; i < 32; i++) begin
            d = 16'($urandom);
            a = 16'(i * 2);
            txn(a, 2'b11, d, rd, lat, after);
            model_access(a, 2'b11, d);
        end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) a = 16'($urandom_range(16'h2000, 16'hFFFF));
            else                           a = 16'($urandom_range(0, 63));
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) s = 2'b00;
            d = 16'($urandom);
            txn(a, s, d, rd, lat, after);
            model_access(a, s, d);
            checks++;
            if (rd !== exp_rd || lat != W + 1 || after !== 1'b0)
                $display("FAIL random[%0d] a=%h s=%b got=%h/%0d/%b exp=%h/%0d/0",
                         i, a, s, rd, lat, after, exp_rd, W + 1);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        bit exp;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 16'h0010;
        mem_wstrb = 2'b00;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            exp = ((n - 1) % (W + 2)) == W;
            checks++;
            if (mem_ready !== exp) $display("FAIL b2b_ready[%0d] got=%b exp=%b", n, mem_ready, exp);
            else passed++;
        end
        mem_valid = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;
        exp_rd = mem_rdata;
    endtask

    task automatic test_reset_keeps_ram;
        logic [15:0] rd;
        int lat;
        logic after;
        bit seen;
        txn(16'h0030, 2'b11, 16'h1357, rd, lat, after);
        model_access(16'h0030, 2'b11, 16'h1357);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 16'h0030;
        mem_wstrb = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            seen = mem_ready;
        end
        checks++;
        if (!seen || mem_rdata !== 16'h1357)
            $display("FAIL rst_resp_pre got=%h/%b exp=1357/1", mem_rdata, seen);
        else passed++;
        rst = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== 16'h0000)
            $display("FAIL rst_resp_clear got=%h/%b exp=0000/0", mem_rdata, mem_ready);
        else passed++;
        rst = 1'b0;
        txn(16'h0030, 2'b00, 16'h0000, rd, lat, after);
        checks++;
        if (rd !== 16'h1357) $display("FAIL rst_ram_kept got=%h exp=1357", rd);
        else passed++;
    endtask

`ifdef MEM_CTRL_WAIT_EN
    task automatic test_reset_during_wait;
        logic [15:0] rd;
        int lat;
        logic after;
        txn(16'h0020, 2'b11, 16'h5555, rd, lat, after);
        model_access(16'h0020, 2'b11, 16'h5555);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 16'h0020;
        mem_wstrb = 2'b11;
        mem_wdata = 16'hAAAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== 16'h0000)
            $display("FAIL wait_rst_clear got=%h/%b exp=0000/0", mem_rdata, mem_ready);
        else passed++;
        rst = 1'b0;
        txn(16'h0020, 2'b00, 16'h0000, rd, lat, after);
        checks++;
        if (rd !== 16'h5555) $display("FAIL wait_rst_no_commit got=%h exp=5555", rd);
        else passed++;
    endtask

    task automatic test_valid_drop;
        logic [15:0] rd;
        int lat;
        logic after;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 16'h0022;
        mem_wstrb = 2'b11;
        mem_wdata = 16'hC0DE;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        mem_wdata = 16'h0000;
        lat = -1;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = i;
                break;
            end
        end
        model_access(16'h0022, 2'b11, 16'hC0DE);
        checks++;
        if (lat != W + 1) $display("FAIL drop_latency got=%0d exp=%0d", lat, W + 1);
        else passed++;
        @(posedge clk); #1;
        txn(16'h0022, 2'b00, 16'h0000, rd, lat, after);
        checks++;
        if (rd !== 16'hC0DE) $display("FAIL drop_commit got=%h exp=C0DE", rd);
        else passed++;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_byte_strobe;
        test_unmapped;
        test_random;
        test_back_to_back;
        test_reset_keeps_ram;
`ifdef MEM_CTRL_WAIT_EN
        test_reset_during_wait;
        test_valid_drop;
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL use one clock and synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-002 Parameter DEPTH_LOG2, default 12, SHALL set the number of 16-bit words to 2**DEPTH_LOG2.
REQ-003 Parameter BASE_ADDR, default 16'h0000, SHALL set the byte address of word 0.
REQ-004 Parameter WAIT_CYCLES, default 0, range 0..15, SHALL set extra wait states per access.
REQ-005 Ports SHALL be:
  clk        in   1   system clock
  rst        in   1   synchronous active-high reset
  mem_valid  in   1   core request; held until mem_ready seen
  mem_wstrb  in   2   byte write enables; 2'b00 = read; [0] = bits 7:0, [1] = bits 15:8
  mem_addr   in   16  byte address; bit 0 ignored
  mem_wdata  in   16  write data
  mem_rdata  out  16  registered read data
  mem_ready  out  1   one-cycle completion pulse

Function
REQ-006 FSM states SHALL be IDLE, WAIT, RESP.
REQ-007 In IDLE with mem_valid=1, the block SHALL latch addr/wstrb/wdata, then go to RESP if the effective wait count is 0, else load the counter with WAIT_CYCLES-1 and go to WAIT.
REQ-008 In WAIT, the counter SHALL decrement each cycle; at 0, the FSM SHALL go to RESP on the next edge.
REQ-009 mem_ready SHALL be 1 only in RESP; RESP SHALL last exactly one cycle and always return to IDLE.
REQ-010 With zero waits, mem_ready SHALL be high in the cycle immediately after the first edge that samples mem_valid=1; each wait state adds one cycle.
REQ-011 The write SHALL commit, and read data SHALL load into mem_rdata, on the edge that enters RESP.
REQ-012 A request is mapped when word index (mem_addr-BASE_ADDR)>>1 is less than 2**DEPTH_LOG2, with 16-bit wrap-around subtraction.
REQ-013 Unmapped reads SHALL return 16'h0000; unmapped writes SHALL be dropped; both SHALL still complete with mem_ready.
REQ-014 Write cycles SHALL leave mem_rdata unchanged.
REQ-015 A read SHALL return the updated data after a prior write to the same word; there SHALL be no read-after-write hazard.
REQ-016 mem_valid, if still high in the IDLE cycle after RESP, SHALL start a new transaction; no back-to-back RESP is possible.
REQ-017 If mem_valid drops during WAIT, the latched transaction SHALL still complete.

Reset
REQ-018 Reset SHALL force: FSM=IDLE, mem_ready=0, mem_rdata=16'h0000, counter=0.
REQ-019 Reset during WAIT SHALL abandon the transaction with no write commit.
REQ-020 Reset SHALL NOT clear RAM contents.

Configuration
REQ-021 With MEM_CTRL_WAIT_EN defined, the WAIT state and counter SHALL be built and WAIT_CYCLES SHALL apply.
REQ-022 Without MEM_CTRL_WAIT_EN, WAIT and the counter SHALL be absent, WAIT_CYCLES SHALL be ignored, and latency SHALL be fixed at zero waits.

Structure
REQ-023 Package mem_ctrl_pkg SHALL hold the state enum and default parameter constants.
REQ-024 Sub-module mem_ctrl_ram SHALL implement the single-port, byte-enabled, synchronous-write array; mem_ctrl SHALL hold the FSM, decode, and counter.

Verification
REQ-025 Write 16'hBEEF to 16'h0010 with wstrb=11, then read 16'h0010 -> mem_rdata=16'hBEEF, with mem_ready one cycle after each valid (WAIT_CYCLES=0).
REQ-026 Write 16'h1234 with wstrb=01 over 16'hBEEF at 16'h0010 -> read returns 16'hBE34.
REQ-027 With MEM_CTRL_WAIT_EN and WAIT_CYCLES=3, read -> mem_ready rises on the 4th cycle after valid is first sampled, and stays high for exactly 1 cycle.
REQ-028 Read 16'hF000 with DEPTH_LOG2=12 and BASE_ADDR=0 -> mem_ready pulses, mem_rdata=16'h0000; a write there leaves the RAM unchanged.
REQ-029 With WAIT_CYCLES=3, assert rst during WAIT of a write of 16'hAAAA to 16'h0020 -> mem_ready=0, mem_rdata=0; a later read of 16'h0020 returns its pre-write value.
REQ-030 Hold mem_valid high continuously -> mem_ready toggles 1,0,1,0 with zero waits, matching the core's handshake.
